// File: rtl/sccb_slave_model_if.sv
// rtl/sccb_slave_model_if.sv - SCCB pad signals and register-write strobe bundle
interface sccb_slave_model_if;
   logic        scl;
   logic        sda_i;
   logic        sda_oe;
   logic        wr_pulse;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;

   modport master (output scl, sda_i, input sda_oe, wr_pulse, wr_addr, wr_data, busy);
   modport slave  (input scl, sda_i, output sda_oe, wr_pulse, wr_addr, wr_data, busy);
endinterface

// File: rtl/sccb_slave_model.sv
// rtl/sccb_slave_model.sv - OV5640-style SCCB responder: 16-bit reg address, 8-bit data, fixed chip ID
// Optional SCCB_SLV_GLITCH_FILT_EN adds a 3-tap majority filter on synchronised SCL/SDA.
module sccb_slave_model #(
   parameter logic [6:0]  SLAVE_ADDR   = 7'h3c,
   parameter int          REG_AW       = 8,
   parameter logic [15:0] CHIP_ID      = 16'h5640,
   parameter logic [15:0] CHIP_ID_ADDR = 16'h300a
) (
   input  logic              clk,
   input  logic              rst_n,
   sccb_slave_model_if.slave bus
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_DEV_ADDR  = 4'd1;
   localparam logic [3:0] S_ACK       = 4'd2;
   localparam logic [3:0] S_ADDR_HI   = 4'd3;
   localparam logic [3:0] S_ADDR_LO   = 4'd4;
   localparam logic [3:0] S_WR_DATA   = 4'd5;
   localparam logic [3:0] S_RD_DATA   = 4'd6;
   localparam logic [3:0] S_RD_ACK    = 4'd7;
   localparam logic [3:0] S_WAIT_STOP = 4'd8;
   localparam int         DEPTH       = 1 << REG_AW;

   logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic        scl_h_q, scl_h_d, sda_h_q, sda_h_d;
   logic        scl_c, sda_c;
   logic        scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
   logic [3:0]  state_q, state_d, next_q, next_d, bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d, rx_byte, rd_byte;
   logic [15:0] reg_addr_q, reg_addr_d, wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        sda_oe_q, sda_oe_d, busy_q, busy_d, ack_on_q, ack_on_d;
   logic        wr_pulse_q, wr_pulse_d, rd_load;
   logic [7:0]  reg_file_q [DEPTH];
   logic [7:0]  reg_file_d [DEPTH];

   always_comb begin
      scl_sync_d = {scl_sync_q[0], bus.scl};
      sda_sync_d = {sda_sync_q[0], bus.sda_i};
      scl_h_d    = scl_c;
      sda_h_d    = sda_c;
   end

`ifdef SCCB_SLV_GLITCH_FILT_EN
   logic [1:0] scl_tap_q, scl_tap_d, sda_tap_q, sda_tap_d;
   logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // A single-clk pulse never occupies two taps at once, so the vote rejects it.
   always_comb begin
      scl_tap_d = {scl_tap_q[0], scl_sync_q[1]};
      sda_tap_d = {sda_tap_q[0], sda_sync_q[1]};
      scl_flt_d = maj3(scl_sync_q[1], scl_tap_q[0], scl_tap_q[1]);
      sda_flt_d = maj3(sda_sync_q[1], sda_tap_q[0], sda_tap_q[1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_tap_q <= 2'b11;
         sda_tap_q <= 2'b11;
         scl_flt_q <= 1'b1;
         sda_flt_q <= 1'b1;
      end else begin
         scl_tap_q <= scl_tap_d;
         sda_tap_q <= sda_tap_d;
         scl_flt_q <= scl_flt_d;
         sda_flt_q <= sda_flt_d;
      end
   end

   assign scl_c = scl_flt_q;
   assign sda_c = sda_flt_q;
`else
   assign scl_c = scl_sync_q[1];
   assign sda_c = sda_sync_q[1];
`endif

   assign scl_rise  = scl_c & ~scl_h_q;
   assign scl_fall  = ~scl_c & scl_h_q;
   assign sda_rise  = sda_c & ~sda_h_q;
   assign sda_fall  = ~sda_c & sda_h_q;
   assign start_det = scl_c & scl_h_q & sda_fall;
   assign stop_det  = scl_c & scl_h_q & sda_rise;
   assign rx_byte   = {shift_q[6:0], sda_c};

   always_comb begin
      if (reg_addr_q == CHIP_ID_ADDR)              rd_byte = CHIP_ID[15:8];
      else if (reg_addr_q == CHIP_ID_ADDR + 16'd1) rd_byte = CHIP_ID[7:0];
      else                                         rd_byte = reg_file_q[reg_addr_q[REG_AW-1:0]];
   end

   always_comb begin
      state_d    = state_q;
      next_d     = next_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      reg_addr_d = reg_addr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      ack_on_d   = ack_on_q;
      wr_pulse_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      reg_file_d = reg_file_q;
      rd_load    = 1'b0;
      if (stop_det) begin
         state_d  = S_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d   = S_DEV_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            S_DEV_ADDR, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     state_d   = S_ACK;
                     ack_on_d  = 1'b0;
                     case (state_q)
                        S_DEV_ADDR: begin
                           if (rx_byte[7:1] == SLAVE_ADDR) begin
                              busy_d = 1'b1;
                              next_d = rx_byte[0] ? S_RD_DATA : S_ADDR_HI;
                           end else begin
                              state_d = S_IDLE;
                              busy_d  = 1'b0;
                           end
                        end
                        S_ADDR_HI: begin
                           reg_addr_d[15:8] = rx_byte;
                           next_d           = S_ADDR_LO;
                        end
                        S_ADDR_LO: begin
                           reg_addr_d[7:0] = rx_byte;
                           next_d          = S_WR_DATA;
                        end
                        default: begin
                           reg_file_d[reg_addr_q[REG_AW-1:0]] = rx_byte;
                           wr_pulse_d = 1'b1;
                           wr_addr_d  = reg_addr_q;
                           wr_data_d  = rx_byte;
                           reg_addr_d = reg_addr_q + 16'd1;
                           next_d     = S_WR_DATA;
                        end
                     endcase
                  end
               end
            end
            S_ACK: begin
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     ack_on_d = 1'b1;
                     sda_oe_d = 1'b1;
                  end else begin
                     state_d  = next_q;
                     sda_oe_d = 1'b0;
                     rd_load  = (next_q == S_RD_DATA);
                  end
               end
            end
            S_RD_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd0) begin
                     rd_load = 1'b1;
                  end else if (bit_cnt_q == 4'd8) begin
                     sda_oe_d = 1'b0;
                     state_d  = S_RD_ACK;
                  end else begin
                     sda_oe_d  = ~shift_q[7];
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_c) begin
                     state_d = S_WAIT_STOP;
                  end else begin
                     reg_addr_d = reg_addr_q + 16'd1;
                     state_d    = S_RD_DATA;
                     bit_cnt_d  = 4'd0;
                  end
               end
            end
            default: ;
         endcase
      end
      // Bit 7 of a read byte goes out on the same fall that ends the preceding ACK slot.
      if (rd_load) begin
         shift_d   = {rd_byte[6:0], 1'b0};
         sda_oe_d  = ~rd_byte[7];
         bit_cnt_d = 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
         state_q    <= S_IDLE;
         next_q     <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         reg_addr_q <= 16'h0000;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         ack_on_q   <= 1'b0;
         wr_pulse_q <= 1'b0;
         wr_addr_q  <= 16'h0000;
         wr_data_q  <= 8'h00;
         for (int i = 0; i < DEPTH; i++) reg_file_q[i] <= 8'h00;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_h_q    <= scl_h_d;
         sda_h_q    <= sda_h_d;
         state_q    <= state_d;
         next_q     <= next_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         reg_addr_q <= reg_addr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         ack_on_q   <= ack_on_d;
         wr_pulse_q <= wr_pulse_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         reg_file_q <= reg_file_d;
      end
   end

   assign bus.sda_oe   = sda_oe_q;
   assign bus.wr_pulse = wr_pulse_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sccb_slave_model.sv
// tb/tb_sccb_slave_model.sv - randomized SCCB master against a register-map reference model
module tb_sccb_slave_model;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        m_sda;
   int          n_vec = 0;
   int          n_err = 0;
   int          cap_rd = 0;
   int          oe_cnt = 0;
   int          busy_cnt = 0;
   logic [7:0]  mmem [256];
   logic [15:0] mptr;
   logic [23:0] cap_q [$];
   logic [23:0] exp_q [$];
   logic [7:0]  wq [$];

   sccb_slave_model_if bus ();
   assign bus.sda_i = m_sda & ~bus.sda_oe;

   sccb_slave_model dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.wr_pulse) cap_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.sda_oe) oe_cnt++;
      if (bus.busy) busy_cnt++;
   end

   task automatic tk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] m_rd(input logic [15:0] a);
      if (a == 16'h300a) return 8'h56;
      if (a == 16'h300b) return 8'h40;
      return mmem[a[7:0]];
   endfunction

   task automatic model_reset;
      for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
      mptr = 16'h0000;
   endtask

   task automatic bus_start;
      if (bus.scl == 1'b0) begin
         tk(5); m_sda = 1'b1; tk(5); bus.scl = 1'b1; tk(5);
      end
      m_sda = 1'b0; tk(5); bus.scl = 1'b0;
   endtask

   task automatic bus_stop;
      tk(5); m_sda = 1'b0; tk(5); bus.scl = 1'b1; tk(5); m_sda = 1'b1; tk(10);
   endtask

   task automatic send_byte(input logic [7:0] b, input int glitch_at, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         tk(5); m_sda = b[i];
         if (i == glitch_at) begin
            tk(2); bus.scl = 1'b1; tk(1); bus.scl = 1'b0; tk(2);
         end else begin
            tk(5);
         end
         bus.scl = 1'b1; tk(10); bus.scl = 1'b0;
      end
      tk(5); m_sda = 1'b1; tk(5); bus.scl = 1'b1; tk(5); ack = bus.sda_i; tk(5); bus.scl = 1'b0;
   endtask

   task automatic recv_byte(input logic nack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         tk(5); m_sda = 1'b1; tk(5); bus.scl = 1'b1; tk(5); b[i] = bus.sda_i; tk(5); bus.scl = 1'b0;
      end
      tk(5); m_sda = nack; tk(5); bus.scl = 1'b1; tk(10); bus.scl = 1'b0;
   endtask

   task automatic addr_phase(input logic [15:0] a);
      logic ack;
      bus_start;
      send_byte(8'h78, -1, ack); check("ack_dev_w", 32'(ack), 0);
      check("busy_on", 32'(bus.busy), 1);
      send_byte(a[15:8], -1, ack); check("ack_addr_hi", 32'(ack), 0);
      send_byte(a[7:0], -1, ack);  check("ack_addr_lo", 32'(ack), 0);
      mptr = a;
   endtask

   task automatic check_writes;
      logic [23:0] e;
      check("wr_count", 32'(cap_q.size() - cap_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (cap_rd < cap_q.size()) begin
            check("wr_addr_data", 32'(cap_q[cap_rd]), 32'(e));
            cap_rd++;
         end
      end
      cap_rd = cap_q.size();
   endtask

   task automatic do_write(input logic [15:0] a);
      logic ack;
      addr_phase(a);
      foreach (wq[k]) begin
         send_byte(wq[k], -1, ack); check("ack_wr", 32'(ack), 0);
         mmem[mptr[7:0]] = wq[k];
         exp_q.push_back({mptr, wq[k]});
         mptr++;
      end
      bus_stop;
      check("busy_off_w", 32'(bus.busy), 0);
      check_writes;
   endtask

   task automatic do_read(input logic [15:0] a, input bit with_addr, input int n);
      logic       ack;
      logic [7:0] b;
      if (with_addr) addr_phase(a);
      bus_start;
      send_byte(8'h79, -1, ack); check("ack_dev_r", 32'(ack), 0);
      for (int k = 0; k < n; k++) begin
         recv_byte(k == n - 1, b);
         check("rd_byte", 32'(b), 32'(m_rd(mptr)));
         if (k != n - 1) mptr++;
      end
      tk(3); check("oe_after_nack", 32'(bus.sda_oe), 0);
      bus_stop;
      check("busy_off_r", 32'(bus.busy), 0);
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic        ack;
      logic [7:0]  d, exp_byte;
      logic [15:0] ra;
      int          oe0, busy0;
      bit          bq [$];

      rst_n = 1'b0; bus.scl = 1'b1; m_sda = 1'b1;
      model_reset;
      tk(4);
      check("rst_sda_oe", 32'(bus.sda_oe), 0);
      check("rst_wr_pulse", 32'(bus.wr_pulse), 0);
      check("rst_wr_addr", 32'(bus.wr_addr), 0);
      check("rst_wr_data", 32'(bus.wr_data), 0);
      check("rst_busy", 32'(bus.busy), 0);
      rst_n = 1'b1; tk(4);

      wq = '{8'h11}; do_write(16'h3108);
      do_read(16'h3108, 1'b1, 1);

      wq = '{8'hff}; do_write(16'h300a);
      do_read(16'h300a, 1'b1, 2);

      oe0 = oe_cnt; busy0 = busy_cnt;
      bus_start;
      send_byte(8'h7a, -1, ack); check("nack_dev", 32'(ack), 1);
      send_byte(8'h12, -1, ack); check("nack_data0", 32'(ack), 1);
      send_byte(8'h34, -1, ack); check("nack_data1", 32'(ack), 1);
      bus_stop;
      check("no_oe_other_dev", 32'(oe_cnt - oe0), 0);
      check("no_busy_other_dev", 32'(busy_cnt - busy0), 0);
      check_writes;

      wq = '{8'haa, 8'hbb}; do_write(16'h00ff);
      wq = '{8'h12, 8'h34}; do_write(16'hffff);
      do_read(16'h0000, 1'b0, 1);

      // Unfiltered SCL sees the glitch as an extra clock that repeats the bit on the line.
      d = 8'ha5;
      addr_phase(16'h0010);
      send_byte(d, 4, ack);
`ifdef SCCB_SLV_GLITCH_FILT_EN
      check("ack_glitch", 32'(ack), 0);
      exp_byte = d;
`else
      for (int i = 7; i >= 0; i--) begin
         bq.push_back(d[i]);
         if (i == 4) bq.push_back(d[i]);
      end
      for (int i = 0; i < 8; i++) exp_byte[7-i] = bq[i];
`endif
      mmem[8'h10] = exp_byte;
      exp_q.push_back({16'h0010, exp_byte});
      mptr = 16'h0011;
      bus_stop;
      check_writes;

      for (int it = 0; it < 12; it++) begin
         ra = 16'($urandom);
         wq.delete();
         for (int k = 0; k < $urandom_range(1, 3); k++) wq.push_back(8'($urandom));
         do_write(ra);
         case ($urandom_range(0, 2))
            0:       do_read(ra, 1'b1, $urandom_range(1, 3));
            1:       do_read(16'h0000, 1'b0, $urandom_range(1, 3));
            default: do_read(16'($urandom), 1'b1, $urandom_range(1, 3));
         endcase
      end

      addr_phase(16'h300b);
      bus_start;
      send_byte(8'h79, -1, ack); check("ack_dev_r_rst", 32'(ack), 0);
      tk(8);
      check("oe_drive_zero", 32'(bus.sda_oe), 1);
      rst_n = 1'b0;
      #1 check("oe_async_reset", 32'(bus.sda_oe), 0);
      tk(2); m_sda = 1'b1; tk(2); bus.scl = 1'b1; tk(3);
      rst_n = 1'b1; tk(5);
      model_reset;
      cap_rd = cap_q.size();
      check("busy_after_rst", 32'(bus.busy), 0);
      wq = '{8'h5a}; do_write(16'h0020);
      do_read(16'h0000, 1'b0, 1);
      do_read(16'h0020, 1'b1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
